// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm controller: FSM state encoding,
// down-counter width and the legal bounds of a stored alarm time.
package alarm_pkg;

  localparam int CNT_W    = 10;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZING = 2'd3
  } alarm_state_e;

endpackage

// File: rtl/sec_tick_detect.sv
// Flags the cycle in which the time-of-day seconds value differs from the
// previous cycle's sample; held quiet in the first cycle after reset.
module sec_tick_detect (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sec_in,
  output logic       tick
);

  logic [7:0] sec_prev;
  logic       first;

  // NOTE: registered state always uses non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    sec_prev <= sec_in;
    if (rst) begin
      first <= 1'b1;
    end else begin
      first <= 1'b0;
    end
  end

  assign tick = ~first & (sec_in != sec_prev);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: stores the alarm time, detects the alarm minute,
// and sequences ringing, snoozing and auto-stop with a shared down-counter.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] current_hour,
  input  logic [7:0] current_minute,
  input  logic [7:0] current_second,
  input  logic       set_en,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_minute,
  input  logic       arm,
  input  logic       disarm,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_minute,
  output logic [1:0] state,
  output logic       ringing,
  output logic [1:0] snooze_count,
  output logic       set_err
);

  localparam logic [CNT_W-1:0] RING_LOAD    = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD  = CNT_W'(SNOOZE_MIN * 60);
  localparam logic [1:0]       SNOOZE_LIMIT = 2'(MAX_SNOOZE);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sc_q, sc_d;
  logic [7:0]       hour_q, minute_q;
  logic             set_err_q;
  logic             sec_tick;
  logic             match;
  logic             set_allowed;
  logic             set_valid;

  sec_tick_detect u_sec_tick (
    .clk    (clk),
    .rst    (rst),
    .sec_in (current_second),
    .tick   (sec_tick)
  );

  assign match = sec_tick && (current_second == 8'd0) &&
                 (current_hour == hour_q) && (current_minute == minute_q);

  // The alarm time is frozen while an alarm event is in progress.
  assign set_allowed = set_en && ((state_q == DISARMED) || (state_q == ARMED));
  assign set_valid   = (set_hour <= 8'(MAX_HOUR)) && (set_minute <= 8'(MAX_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q    <= 8'd7;
      minute_q  <= 8'd0;
      set_err_q <= 1'b0;
    end else begin
      set_err_q <= set_allowed && !set_valid;
      if (set_allowed && set_valid) begin
        hour_q   <= set_hour;
        minute_q <= set_minute;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISARMED;
      cnt_q   <= '0;
      sc_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sc_d    = sc_q;
    unique case (state_q)
      DISARMED: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (disarm) begin
          state_d = DISARMED;
        end else if (match) begin
          state_d = RINGING;
          cnt_d   = RING_LOAD;
          sc_d    = 2'd0;
        end
      end
      RINGING: begin
        if (disarm) begin
          state_d = DISARMED;
          cnt_d   = '0;
        end else if (stop) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else if (snooze && (sc_q < SNOOZE_LIMIT)) begin
          state_d = SNOOZING;
          cnt_d   = SNOOZE_LOAD;
          sc_d    = sc_q + 2'd1;
        end else if (sec_tick) begin
          // A refused snooze falls through here, so auto-stop still runs.
          if (cnt_q == CNT_W'(1)) state_d = ARMED;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SNOOZING: begin
        if (disarm) begin
          state_d = DISARMED;
          cnt_d   = '0;
        end else if (stop) begin
          state_d = ARMED;
          cnt_d   = '0;
        end else if (sec_tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = RINGING;
            cnt_d   = RING_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = DISARMED;
    endcase
  end

  assign alarm_hour   = hour_q;
  assign alarm_minute = minute_q;
  assign state        = state_q;
  assign ringing      = (state_q == RINGING);
  assign snooze_count = sc_q;
  assign set_err      = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: a constant vector table, directed multi-cycle
// scenarios, and randomized traffic checked against a behavioural model.
module tb_alarm_ctrl;

  localparam int RING_T  = 60;
  localparam int SNZ_T   = 5 * 60;
  localparam int MAX_SNZ = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cur_h = 0, cur_m = 0, cur_s = 0;
  logic       set_en = 0;
  logic [7:0] set_h = 0, set_m = 0;
  logic       arm = 0, disarm = 0, snooze = 0, stop = 0;
  logic [7:0] alarm_hour, alarm_minute;
  logic [1:0] state;
  logic       ringing;
  logic [1:0] snooze_count;
  logic       set_err;

  int n_cmp  = 0;
  int n_fail = 0;

  alarm_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .current_hour   (cur_h),
    .current_minute (cur_m),
    .current_second (cur_s),
    .set_en         (set_en),
    .set_hour       (set_h),
    .set_minute     (set_m),
    .arm            (arm),
    .disarm         (disarm),
    .snooze         (snooze),
    .stop           (stop),
    .alarm_hour     (alarm_hour),
    .alarm_minute   (alarm_minute),
    .state          (state),
    .ringing        (ringing),
    .snooze_count   (snooze_count),
    .set_err        (set_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: states 0..3, "remaining seconds" for the current phase.
  int m_state, m_ah, m_am, m_sc, m_left, m_err, m_prev;
  bit m_first;

  function automatic void model_step();
    bit tick, match;
    if (rst) begin
      m_state = 0; m_ah = 7; m_am = 0; m_sc = 0; m_left = 0; m_err = 0;
      m_prev = int'(cur_s); m_first = 1;
      return;
    end
    tick    = !m_first && (int'(cur_s) != m_prev);
    m_first = 0;
    m_prev  = int'(cur_s);
    match   = tick && cur_s == 0 && int'(cur_h) == m_ah && int'(cur_m) == m_am;
    m_err   = 0;
    if (set_en && m_state <= 1) begin
      if (set_h <= 23 && set_m <= 59) begin
        m_ah = int'(set_h); m_am = int'(set_m);
      end else begin
        m_err = 1;
      end
    end
    case (m_state)
      0: if (arm) m_state = 1;
      1: if (disarm) m_state = 0;
         else if (match) begin m_state = 2; m_left = RING_T; m_sc = 0; end
      2: if (disarm) m_state = 0;
         else if (stop) m_state = 1;
         else if (snooze && m_sc < MAX_SNZ) begin m_state = 3; m_sc++; m_left = SNZ_T; end
         else if (tick) begin m_left--; if (m_left == 0) m_state = 1; end
      default: if (disarm) m_state = 0;
         else if (stop) m_state = 1;
         else if (tick) begin m_left--; if (m_left == 0) begin m_state = 2; m_left = RING_T; end end
    endcase
  endfunction

  // One clock: model consumes the present inputs, DUT sees the edge,
  // outputs are then sampled 1 time unit later and pulses are dropped.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    set_en = 0; arm = 0; disarm = 0; snooze = 0; stop = 0;
  endtask

  task automatic adv_sec();
    cur_s = cur_s + 8'd1;
    if (cur_s == 60) begin cur_s = 0; cur_m = cur_m + 8'd1; end
    if (cur_m == 60) begin cur_m = 0; cur_h = cur_h + 8'd1; end
    if (cur_h == 24) cur_h = 0;
  endtask

  task automatic tick_sec();
    adv_sec();
    cycle();
  endtask

  // Reset, set 06:30 with arm, then walk 06:29:59 -> 06:30:00.
  task automatic to_ringing(input string tag);
    rst = 1; cur_h = 6; cur_m = 29; cur_s = 58;
    cycle();
    rst = 0; set_en = 1; set_h = 6; set_m = 30; arm = 1;
    cycle();
    cur_s = 59;
    cycle();
    check({tag, "_pre_ring"}, ringing, 0);
    cur_m = 30; cur_s = 0;
    cycle();
    check({tag, "_ring_rise"}, ringing, 1);
    check({tag, "_sc_zero"}, snooze_count, 0);
  endtask

  typedef struct {
    logic       rst, set_en;
    logic [7:0] sh, sm;
    logic       arm, disarm, snooze, stop;
    logic [7:0] h, m, s;
    logic [1:0] e_state;
    logic [7:0] e_ah, e_am;
    logic       e_err, e_ring;
    logic [1:0] e_sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, se, input int sh, sm, input logic a, d, z, p,
                     input int h, m, s, input int est, eah, eam, input logic eerr, ering,
                     input int esc);
    vec_t v;
    v.rst = r; v.set_en = se; v.sh = 8'(sh); v.sm = 8'(sm);
    v.arm = a; v.disarm = d; v.snooze = z; v.stop = p;
    v.h = 8'(h); v.m = 8'(m); v.s = 8'(s);
    v.e_state = 2'(est); v.e_ah = 8'(eah); v.e_am = 8'(eam);
    v.e_err = eerr; v.e_ring = ering; v.e_sc = 2'(esc);
    vecs.push_back(v);
  endtask

  initial begin
    //   rst se sh sm a d z p  h  m  s   st ah am err ring sc
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0);
    add(0, 1, 24, 10, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 7, 0, 0, 0, 0);
    add(0, 1, 23, 59, 0, 0, 0, 0, 0, 0, 0, 0, 23, 59, 0, 0, 0);
    add(0, 1, 23, 60, 0, 0, 0, 0, 0, 0, 0, 0, 23, 59, 1, 0, 0);
    add(0, 1, 6, 30, 1, 0, 0, 0, 0, 0, 0,  1, 6, 30, 0, 0, 0);
    add(0, 1, 6, 60, 0, 0, 0, 0, 0, 0, 0,  1, 6, 30, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 6, 29, 59, 1, 6, 30, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 6, 30, 0,  2, 6, 30, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 6, 30, 0,  2, 6, 30, 0, 1, 0);
    add(0, 1, 99, 99, 0, 0, 0, 0, 6, 30, 0, 2, 6, 30, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 6, 30, 0,  3, 6, 30, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 1, 6, 30, 0,  0, 6, 30, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 6, 30, 0,  1, 6, 30, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 6, 30, 0,  1, 6, 30, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 6, 30, 0,  0, 6, 30, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 1, 6, 30, 0,  0, 6, 30, 0, 0, 1);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; set_en = vecs[i].set_en; set_h = vecs[i].sh; set_m = vecs[i].sm;
      arm = vecs[i].arm; disarm = vecs[i].disarm; snooze = vecs[i].snooze; stop = vecs[i].stop;
      cur_h = vecs[i].h; cur_m = vecs[i].m; cur_s = vecs[i].s;
      cycle();
      check($sformatf("vec%0d_state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d_ahour", i), alarm_hour, vecs[i].e_ah);
      check($sformatf("vec%0d_amin", i), alarm_minute, vecs[i].e_am);
      check($sformatf("vec%0d_set_err", i), set_err, vecs[i].e_err);
      check($sformatf("vec%0d_ringing", i), ringing, vecs[i].e_ring);
      check($sformatf("vec%0d_sc", i), snooze_count, vecs[i].e_sc);
    end

    // Auto-stop: exactly RING_T ticks of ringing; idle cycles do not count.
    to_ringing("auto");
    for (int t = 1; t <= RING_T; t++) begin
      tick_sec();
      check($sformatf("auto_tick%0d_ring", t), ringing, (t < RING_T) ? 1 : 0);
      cycle();
    end
    check("auto_end_state", state, 1);

    // Three full snooze cycles, then a refused fourth snooze.
    to_ringing("snz");
    for (int k = 1; k <= MAX_SNZ; k++) begin
      snooze = 1;
      cycle();
      check($sformatf("snz%0d_state", k), state, 3);
      check($sformatf("snz%0d_count", k), snooze_count, k);
      for (int t = 1; t <= SNZ_T; t++) begin
        tick_sec();
        if (t >= SNZ_T - 1) check($sformatf("snz%0d_t%0d_state", k, t), state, (t < SNZ_T) ? 3 : 2);
      end
    end
    snooze = 1;
    cycle();
    check("snz4_state", state, 2);
    check("snz4_count", snooze_count, 3);
    check("snz4_ringing", ringing, 1);

    stop = 1; disarm = 1;
    cycle();
    check("stop_disarm_state", state, 0);

    // Reset during snooze with 120 s remaining, then no ring without a tick.
    to_ringing("rst");
    snooze = 1;
    cycle();
    for (int t = 0; t < 180; t++) tick_sec();
    check("rst_pre_state", state, 3);
    check("rst_pre_cnt", int'(dut.cnt_q), 120);
    rst = 1; snooze = 1; stop = 1; arm = 1; cur_h = 6; cur_m = 30; cur_s = 0;
    cycle();
    check("rst_state", state, 0);
    check("rst_cnt", int'(dut.cnt_q), 0);
    check("rst_ringing", ringing, 0);
    check("rst_sc", snooze_count, 0);
    rst = 0; set_en = 1; set_h = 6; set_m = 30; arm = 1;
    cycle();
    check("rst_rearm_state", state, 1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      check($sformatf("rst_hold%0d_ring", c), ringing, 0);
    end

    // Randomized traffic against the model, time confined to 00:00-00:09.
    rst = 1; cur_h = 0; cur_m = 0; cur_s = 0;
    cycle();
    rst = 0;
    for (int c = 0; c < 20000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      rst = (r == 0);
      r = $urandom_range(0, 99);
      if (r < 2) arm = 1;
      else if (r == 2) disarm = 1;
      else if (r < 5) snooze = 1;
      else if (r == 5) stop = 1;
      else if (r == 6) disarm = 1'b1 && ($urandom_range(0, 1) == 1);
      if (r >= 7 && r < 10) begin
        set_en = 1;
        set_h  = ($urandom_range(0, 3) != 0) ? 8'd0 : 8'($urandom_range(0, 30));
        set_m  = ($urandom_range(0, 6) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom_range(0, 70));
        arm    = (r == 9);
      end
      if ($urandom_range(0, 1) == 1) begin
        adv_sec();
        if (cur_m == 10) cur_m = 0;
        cur_h = 0;
      end
      cycle();
      check("rnd_state", state, m_state);
      check("rnd_ringing", ringing, (m_state == 2) ? 1 : 0);
      check("rnd_ahour", alarm_hour, m_ah);
      check("rnd_amin", alarm_minute, m_am);
      check("rnd_sc", snooze_count, m_sc);
      check("rnd_set_err", set_err, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter SNOOZE_MIN, default 5: snooze length in minutes, legal range 1..15.
REQ-002 SHALL have parameter RING_SEC, default 60: auto-stop ring duration in seconds, legal range 1..1023.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event, legal range 0..3.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have ports current_hour, current_minute, current_second, input, 8 each: unsigned time of day from the time-of-day counter.
REQ-007 SHALL have port set_en, input, 1: one-cycle request to load the alarm time.
REQ-008 SHALL have ports set_hour, set_minute, input, 8 each: candidate alarm time, sampled when set_en=1.
REQ-009 SHALL have ports arm, disarm, snooze, stop, input, 1 each: one-cycle command pulses.
REQ-010 SHALL have ports alarm_hour, alarm_minute, output, 8 each: stored alarm time.
REQ-011 SHALL have port state, output, 2: DISARMED=0, ARMED=1, RINGING=2, SNOOZING=3.
REQ-012 SHALL have port ringing, output, 1: high exactly while state==RINGING.
REQ-013 SHALL have port snooze_count, output, 2: snoozes used in the current alarm event.
REQ-014 SHALL have port set_err, output, 1: one-cycle pulse when a set request is rejected.

Function
REQ-015 SHALL register current_second each cycle; sec_tick = (current_second != previous sample); sec_tick SHALL be forced to 0 in the first cycle after reset.
REQ-016 SHALL define match = sec_tick AND current_second==0 AND current_hour==alarm_hour AND current_minute==alarm_minute.
REQ-017 On set_en, SHALL load the alarm only if set_hour<=23 and set_minute<=59; otherwise SHALL hold the old value and pulse set_err in the next cycle.
REQ-018 SHALL ignore set_en while in RINGING or SNOOZING, with no set_err pulse.
REQ-019 DISARMED: arm -> ARMED; all other commands ignored.
REQ-020 ARMED: disarm -> DISARMED; else match -> RINGING, load down-counter with RING_SEC, and clear snooze_count.
REQ-021 RINGING: priority is disarm (-> DISARMED) > stop (-> ARMED) > snooze (-> SNOOZING) > timeout (-> ARMED).
REQ-022 RINGING: snooze SHALL be accepted only if snooze_count<MAX_SNOOZE; on acceptance, increment snooze_count and load the counter with SNOOZE_MIN*60. A refused snooze SHALL be ignored.
REQ-023 RINGING: decrement the counter on each sec_tick; timeout SHALL occur on the sec_tick at which the counter is 1.
REQ-024 SNOOZING: disarm -> DISARMED; stop -> ARMED; decrement on each sec_tick; on the sec_tick at which the counter is 1 -> RINGING, reloading RING_SEC.
REQ-025 The down-counter SHALL be 10 bits, unsigned, shared between RINGING and SNOOZING.
REQ-026 All state and output updates SHALL take effect one cycle after the causing input. ringing SHALL rise one cycle after the match cycle.
REQ-027 A match while in RINGING, SNOOZING or DISARMED SHALL be ignored.
REQ-028 Simultaneous set_en and arm SHALL both take effect in the same cycle.

Reset
REQ-029 While rst=1: state=DISARMED, alarm_hour=7, alarm_minute=0, snooze_count=0, counter=0, set_err=0, ringing=0, and the second sample=current_second.
REQ-030 rst asserted mid-RINGING or mid-SNOOZING SHALL abort to DISARMED on the next edge; rst SHALL override all commands.

Structure
REQ-031 Package alarm_pkg SHALL hold the state enum (2-bit), the width constant CNT_W=10, and the limits MAX_HOUR=23 and MAX_MIN=59.
REQ-032 Second-edge detection SHALL be a sub-module sec_tick_detect (ports clk, rst, sec_in, tick); the FSM, counter and set logic SHALL remain in alarm_ctrl.

Verification
REQ-033 Set 06:30 then arm; drive time 06:29:59 -> 06:30:00 -> ringing=1 one cycle after the second changes, snooze_count=0.
REQ-034 RINGING, RING_SEC=60, no input -> ringing stays high for 60 sec_ticks, then state=ARMED.
REQ-035 RINGING, snooze x3 with MAX_SNOOZE=3, each snooze running the full 300 ticks to re-ring -> 4th snooze ignored, snooze_count=3, ringing stays high.
REQ-036 set_hour=24, set_minute=10 -> set_err pulses for one cycle, alarm_hour/alarm_minute unchanged (7/0 after reset).
REQ-037 stop and disarm asserted in the same cycle while RINGING -> state=DISARMED.
REQ-038 rst=1 while in SNOOZING with counter=120 -> DISARMED with counter=0 next edge; after rst drops, time held at the alarm value with no second change -> no ring.
